pipelined_carry_select_adder: RTL and testbench
===============================================

// Module: pipelined_carry_select_adder
// PURPOSE
//   Parametrised, pipelined carry-select adder/subtractor for wide datapaths where a single-cycle carry chain misses timing.
//   The operand is split into SEG-bit segments. Each segment precomputes sum/carry for carry-in 0 and 1, then muxes on the real carry.
//   Segments are spread over PIPE register stages behind a valid/ready handshake with full backpressure.
// PARAMETERS
//   WIDTH  16  operand/result width in bits
//   SEG    4   segment width; WIDTH % SEG == 0 required
//   PIPE   2   pipeline stages (= latency); (WIDTH/SEG) % PIPE == 0 required
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous reset, active low
//   in_valid   in   1      operand beat valid
//   in_ready   out  1      block accepts the beat this cycle
//   in_a       in   WIDTH  operand A
//   in_b       in   WIDTH  operand B
//   in_cin     in   1      carry-in (add) / borrow-in (sub)
//   in_op      in   1      0 = add, 1 = subtract
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts the result
//   out_sum    out  WIDTH  result
//   out_cout   out  1      carry-out; in sub mode this is NOT borrow
//   out_ovf    out  1      signed overflow (only when CSA_OVF_EN is defined)
// BEHAVIOUR
//   - Reset (rst_n low, async): all stage valid bits, data, carry regs and outputs clear to 0. in_ready = 1 after reset.
//     A reset mid-stream drops in-flight beats. No stale result may appear after release.
//   - Operand prep: b_eff = in_op ? ~in_b : in_b; c_eff = in_op ? ~in_cin : in_cin.
//     Add computes a+b+cin. Sub computes a-b-cin.
//   - Arithmetic: result = a + b_eff + c_eff, taken modulo 2^WIDTH; out_cout = bit WIDTH.
//   - Stage k (0..PIPE-1) resolves segments k*SPS .. (k+1)*SPS-1, where SPS = WIDTH/(SEG*PIPE).
//     The first segment of stage 0 is a plain ripple adder on c_eff.
//     Every other segment holds two ripple adders (cin=0 and cin=1) and selects on the incoming carry.
//     Within a stage, the carry flows through the select muxes only.
//     The inter-stage carry, resolved low sum bits and unresolved high operand bits are registered.
//   - Pipeline advance: adv = !out_valid | out_ready; in_ready = adv.
//     On adv, every stage loads from the previous stage (stage 0 loads from the inputs, valid = in_valid & in_ready).
//     When adv = 0, all stages and outputs hold. out_sum/out_cout/out_ovf must stay stable while out_valid & !out_ready.
//   - Latency: PIPE cycles from accepted beat to out_valid with no stall. Throughput is 1 beat/cycle when out_ready = 1.
//   - Bubbles: invalid beats advance like valid ones. Bubbles are not squeezed out. Output data under out_valid = 0 is don't-care but must not be X after reset.
//   - Simultaneous accept and output in the same cycle is legal and required for full throughput.
//   - Illegal WIDTH/SEG/PIPE combinations must fail at elaboration via a generate-time error. They must not be silently truncated.
// CONFIGURATION
//   CSA_OVF_EN defined: out_ovf is present. It is registered alongside out_sum, is 0 on reset, and holds under a stall.
//     out_ovf = (a[MSB] == b_eff[MSB]) & (sum[MSB] != a[MSB]).
//   CSA_OVF_EN undefined: no out_ovf port and no overflow logic. All other behaviour is identical.
// TESTING (defaults WIDTH=16, SEG=4, PIPE=2)
//   1. add 0xFFFF + 0x0001, cin=0 -> 2 cycles later out_sum = 0x0000, out_cout = 1.
//   2. sub 0x0005 - 0x0007, cin=0 -> out_sum = 0xFFFE, out_cout = 0; sub 0x0009 - 0x0002, cin=1 -> 0x0006, out_cout = 1.
//   3. 1000 random back-to-back beats (add/sub mixed) with out_ready = 1 -> one result per cycle, latency 2, all match the reference model.
//   4. Pipeline full, out_ready = 0 for 3 cycles -> in_ready = 0 and out_sum stable during the stall; no beat lost or duplicated after release.
//   5. rst_n pulled low with 2 beats in flight -> out_valid = 0 immediately (async); no result emitted after release until a new beat arrives.
//   6. CSA_OVF_EN: 0x7FFF + 0x0001 -> out_ovf = 1; 0x8000 - 0x0001 -> out_ovf = 1, out_sum = 0x7FFF; 0x0003 + 0x0004 -> out_ovf = 0.

Source files
------------

// File: rtl/pipelined_carry_select_adder.sv
// Pipelined carry-select adder/subtractor: WIDTH/SEG segments spread over PIPE register stages.
// Define CSA_OVF_EN to add the registered signed-overflow output out_ovf.
module pipelined_carry_select_adder #(
   parameter int WIDTH = 16,
   parameter int SEG   = 4,
   parameter int PIPE  = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout
`ifdef CSA_OVF_EN
   ,
   output logic             out_ovf
`endif
);

   localparam int NSEG = (SEG > 0) ? WIDTH / SEG : 1;
   localparam int SPS  = (PIPE > 0) ? NSEG / PIPE : 1;
   localparam int SW   = SPS * SEG;

   if (SEG < 1 || PIPE < 1 || (WIDTH % SEG) != 0 || (NSEG % PIPE) != 0) begin : g_bad_cfg
      $error("pipelined_carry_select_adder: WIDTH must divide by SEG and WIDTH/SEG by PIPE");
   end

   logic [PIPE-1:0][WIDTH-1:0] a_q, b_q, s_q;
   logic [PIPE-1:0][WIDTH-1:0] src_a, src_b, src_s, nxt_s;
   logic [PIPE-1:0]            c_q, v_q, src_c, src_v, nxt_c;
   logic [WIDTH-1:0]           b_eff;
   logic                       c_eff;
   logic                       adv;

   // Handshake: a beat transfers on a clock edge where valid & ready are both high.
   // The whole pipe moves as one unit, so any free output slot lets every stage advance.
   assign adv      = !v_q[PIPE-1] | out_ready;
   assign in_ready = adv;
   assign b_eff    = in_op ? ~in_b : in_b;
   assign c_eff    = in_op ? ~in_cin : in_cin;

   for (genvar k = 0; k < PIPE; k++) begin : g_stage
      logic [SPS:0]     cy;
      logic [SW-1:0]    seg_sum;
      logic [WIDTH-1:0] s_n;

      if (k == 0) begin : g_src
         assign src_a[k] = in_a;
         assign src_b[k] = b_eff;
         assign src_s[k] = '0;
         assign src_c[k] = c_eff;
         assign src_v[k] = in_valid & in_ready;
      end else begin : g_src
         assign src_a[k] = a_q[k-1];
         assign src_b[k] = b_q[k-1];
         assign src_s[k] = s_q[k-1];
         assign src_c[k] = c_q[k-1];
         assign src_v[k] = v_q[k-1];
      end

      assign cy[0] = src_c[k];

      for (genvar j = 0; j < SPS; j++) begin : g_seg
         localparam int LO = (k * SPS + j) * SEG;
         if (k == 0 && j == 0) begin : g_ripple
            logic [SEG:0] r;
            assign r = {1'b0, src_a[k][LO +: SEG]} + {1'b0, src_b[k][LO +: SEG]}
                     + {{SEG{1'b0}}, cy[j]};
            assign cy[j+1]              = r[SEG];
            assign seg_sum[j*SEG +: SEG] = r[SEG-1:0];
         end else begin : g_select
            // Both carry-in cases are precomputed; the real carry only drives the mux.
            logic [SEG:0] r0, r1;
            assign r0 = {1'b0, src_a[k][LO +: SEG]} + {1'b0, src_b[k][LO +: SEG]};
            assign r1 = r0 + {{SEG{1'b0}}, 1'b1};
            assign cy[j+1]              = cy[j] ? r1[SEG] : r0[SEG];
            assign seg_sum[j*SEG +: SEG] = cy[j] ? r1[SEG-1:0] : r0[SEG-1:0];
         end
      end

      always_comb begin
         s_n               = src_s[k];
         s_n[k*SW +: SW]   = seg_sum;
      end

      assign nxt_s[k] = s_n;
      assign nxt_c[k] = cy[SPS];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q <= '0;
         b_q <= '0;
         s_q <= '0;
         c_q <= '0;
         v_q <= '0;
      end else if (adv) begin
         a_q <= src_a;
         b_q <= src_b;
         s_q <= nxt_s;
         c_q <= nxt_c;
         v_q <= src_v;
      end
   end

   assign out_valid = v_q[PIPE-1];
   assign out_sum   = s_q[PIPE-1];
   assign out_cout  = c_q[PIPE-1];

`ifdef CSA_OVF_EN
   logic ovf_n, ovf_q;

   // The MSB resolves in the last stage, so overflow is formed there from the carried operands.
   assign ovf_n = (src_a[PIPE-1][WIDTH-1] == src_b[PIPE-1][WIDTH-1])
                & (nxt_s[PIPE-1][WIDTH-1] != src_a[PIPE-1][WIDTH-1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (adv) begin
         ovf_q <= ovf_n;
      end
   end

   assign out_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// Directed-vector bench for pipelined_carry_select_adder at WIDTH=16, SEG=4, PIPE=2.
// Overflow checks are compiled in when CSA_OVF_EN is defined.
module tb_pipelined_carry_select_adder;

   localparam int W  = 16;
   localparam int EW = W + 2;
   localparam int NV = 19;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         op;
      logic [W-1:0] s;
      logic         co;
      logic         ov;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_a = '0;
   logic [W-1:0]  in_b = '0;
   logic          in_cin = 1'b0;
   logic          in_op = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  out_sum;
   logic          out_cout;
`ifdef CSA_OVF_EN
   logic          out_ovf;
`endif

   vec_t          vt [NV];
   logic [EW-1:0] exp_q [$];
   int            cyc_q [$];
   int            cyc = 0;
   int            n_vec = 0;
   int            n_err = 0;
   bit            chk_lat = 1'b1;
   logic [EW-1:0] e;
   int            t;
   int            c0;

   pipelined_carry_select_adder #(.WIDTH(W), .SEG(4), .PIPE(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout)
`ifdef CSA_OVF_EN
      ,
      .out_ovf   (out_ovf)
`endif
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   task automatic load_vectors();
      //          a         b         cin   op    sum       cout  ovf
      vt[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vt[1]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vt[2]  = '{16'h0009, 16'h0002, 1'b1, 1'b1, 16'h0006, 1'b1, 1'b0};
      vt[3]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      vt[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      vt[5]  = '{16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0};
      vt[6]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
      vt[7]  = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
      vt[8]  = '{16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
      vt[9]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
      vt[10] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
      vt[11] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
      vt[12] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
      vt[13] = '{16'h1234, 16'h0234, 1'b0, 1'b1, 16'h1000, 1'b1, 1'b0};
      vt[14] = '{16'h00F0, 16'h0010, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
      vt[15] = '{16'h0100, 16'h0001, 1'b0, 1'b1, 16'h00FF, 1'b1, 1'b0};
      vt[16] = '{16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b1};
      vt[17] = '{16'hA5A5, 16'h5A5A, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0};
      vt[18] = '{16'hA5A5, 16'h5A5B, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
   endtask

   // driver: present a beat and hold it until the DUT takes it
   task automatic send(input int i);
      int n = 0;
      in_valid = 1'b1;
      in_a     = vt[i].a;
      in_b     = vt[i].b;
      in_cin   = vt[i].cin;
      in_op    = vt[i].op;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n >= 50) break;
      end
      if (!in_ready) begin
         check("accept_timeout", 32'd1, 32'd0);
         in_valid = 1'b0;
      end else begin
         exp_q.push_back({vt[i].ov, vt[i].co, vt[i].s});
         cyc_q.push_back(cyc);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain_left", exp_q.size(), 32'd0);
   endtask

   // scoreboard: every output transfer must match the oldest accepted beat
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("spurious_out", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            t = cyc_q.pop_front();
            check("sum", out_sum, e[W-1:0]);
            check("cout", out_cout, e[W]);
`ifdef CSA_OVF_EN
            check("ovf", out_ovf, e[W+1]);
`endif
            if (chk_lat) check("latency", cyc - t, 32'd2);
         end
      end
   end

   initial begin
      load_vectors();

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 32'd0);
      check("rst_in_ready", in_ready, 32'd1);
      check("rst_out_sum", out_sum, 32'd0);
      check("rst_out_cout", out_cout, 32'd0);
`ifdef CSA_OVF_EN
      check("rst_out_ovf", out_ovf, 32'd0);
`endif
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // back-to-back directed vectors, one per cycle
      c0 = cyc;
      for (int i = 0; i < NV; i++) send(i);
      check("throughput_cycles", cyc - c0, NV);
      wait_drain();

      // fill the pipe with the sink stalled, hold 3 cycles, then release
      chk_lat   = 1'b0;
      out_ready = 1'b0;
      send(5);
      send(6);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("stall_in_ready", in_ready, 32'd0);
         check("stall_out_valid", out_valid, 32'd1);
         check("stall_out_sum", out_sum, 32'h0007);
         check("stall_out_cout", out_cout, 32'd0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(7);
      wait_drain();

      // reset with two beats in flight drops them
      chk_lat = 1'b1;
      send(9);
      send(10);
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", out_valid, 32'd0);
      check("async_rst_sum", out_sum, 32'd0);
      exp_q.delete();
      cyc_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("post_rst_valid", out_valid, 32'd0);
      end
      @(posedge clk);
      #1;
      send(4);
      send(18);
      wait_drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=%0d expected=finish", cyc);
      $fatal(1, "bench timed out");
   end

endmodule
